elc_request_scheduler: RTL and testbench

Upstream stage of the elevator controller (`iiitb_elc`). Latches hall/car call buttons into a pending-floor register and selects the next target floor with a SCAN (elevator-algorithm) policy. Presents the target on `request_floor` and holds it until the controller pulses `complete`. Then enforces a door-dwell interval, stalled by door/weight alerts, before dispatching again.

---
 rtl/elc_pkg.sv | 23 ++
 rtl/elc_scan_pick.sv | 100 ++++++++++
 rtl/elc_request_scheduler.sv | 159 +++++++++++++++
 tb/tb_elc_request_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/elc_pkg.sv
// ----------------------------------------------------------------------------
// elc_pkg
// Shared definitions for the elevator request scheduler slice.
//   - state_t       : scheduler FSM states (IDLE, SELECT, DISPATCH, DWELL)
//   - DIR_UP/DOWN   : encoding of the SCAN sweep direction
//   - N_FLOORS_DEFAULT : default building height in floors
// No ports; imported by elc_scan_pick and elc_request_scheduler.
// ----------------------------------------------------------------------------
package elc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPATCH = 2'd2,
        DWELL    = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int N_FLOORS_DEFAULT = 8;

endpackage : elc_pkg

// File: rtl/elc_scan_pick.sv
// ----------------------------------------------------------------------------
// elc_scan_pick
// Purely combinational SCAN (elevator algorithm) target picker.
// Ports:
//   pending   in  [N_FLOORS]  outstanding calls, one bit per floor
//   cur_floor in  [N_FLOORS]  current car position, one-hot (lowest bit used,
//                             all-zero is treated as floor 0)
//   sched_dir in  1           present sweep direction (DIR_UP / DIR_DOWN)
//   target    out [N_FLOORS]  chosen floor, one-hot (zero when nothing pending)
//   found     out 1           at least one call is pending
//   next_dir  out 1           sweep direction after this pick
// ----------------------------------------------------------------------------
module elc_scan_pick
    import elc_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEFAULT
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [N_FLOORS-1:0] cur_floor,
    input  logic                sched_dir,
    output logic [N_FLOORS-1:0] target,
    output logic                found,
    output logic                next_dir
);

    localparam int IW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

    logic [IW-1:0] cur_idx;
    logic [IW-1:0] above_idx;
    logic [IW-1:0] below_idx;
    logic [IW-1:0] pick_idx;
    logic          above_found;
    logic          below_found;

    // Locate the car, then the nearest pending floor on each side of it.
    // Scanning downward and keeping the last hit yields the lowest index,
    // scanning upward yields the highest, which is exactly "nearest above"
    // and "nearest below" respectively.
    always_comb begin
        cur_idx     = '0;
        above_idx   = '0;
        below_idx   = '0;
        above_found = 1'b0;
        below_found = 1'b0;

        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (cur_floor[i]) begin
                cur_idx = IW'(i);
            end
        end

        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (IW'(i) > cur_idx)) begin
                above_found = 1'b1;
                above_idx   = IW'(i);
            end
        end

        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (IW'(i) < cur_idx)) begin
                below_found = 1'b1;
                below_idx   = IW'(i);
            end
        end
    end

    // SCAN priority: serve the current floor first, otherwise keep sweeping
    // in the present direction, and only reverse when nothing lies ahead.
    // When we reverse, the other side must hold the call because 'found'
    // guarantees at least one pending bit somewhere.
    always_comb begin
        pick_idx = cur_idx;
        next_dir = sched_dir;
        found    = |pending;
        target   = '0;

        if (pending[cur_idx]) begin
            pick_idx = cur_idx;
        end else if (sched_dir == DIR_UP) begin
            if (above_found) begin
                pick_idx = above_idx;
            end else if (below_found) begin
                pick_idx = below_idx;
                next_dir = DIR_DOWN;
            end
        end else begin
            if (below_found) begin
                pick_idx = below_idx;
            end else if (above_found) begin
                pick_idx = above_idx;
                next_dir = DIR_UP;
            end
        end

        if (found) begin
            target[pick_idx] = 1'b1;
        end
    end

endmodule : elc_scan_pick

// File: rtl/elc_request_scheduler.sv
// ----------------------------------------------------------------------------
// elc_request_scheduler
// Latches hall/car calls into a pending register and feeds the elevator
// controller one target floor at a time using SCAN ordering, with a door
// dwell interval (stalled by door/weight alerts) between dispatches.
// Ports:
//   clk           in  1           rising-edge clock
//   reset         in  1           synchronous, active-low reset
//   call_valid    in  1           call_floor is valid this cycle
//   call_floor    in  [N_FLOORS]  floors being called (multi-hot allowed)
//   cur_floor     in  [N_FLOORS]  controller's current floor, one-hot
//   complete      in  1           controller reached request_floor (pulse)
//   door_alert    in  1           stalls the dwell countdown
//   weight_alert  in  1           stalls the dwell countdown
//   request_floor out [N_FLOORS]  one-hot target floor (registered)
//   req_valid     out 1           request_floor is live (registered)
//   sched_dir     out 1           SCAN direction, 1 = up (registered)
//   pending       out [N_FLOORS]  outstanding calls (registered)
//   busy          out 1           FSM is not IDLE (decoded from state)
// ----------------------------------------------------------------------------
module elc_request_scheduler
    import elc_pkg::*;
#(
    parameter int N_FLOORS     = N_FLOORS_DEFAULT,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                call_valid,
    input  logic [N_FLOORS-1:0] call_floor,
    input  logic [N_FLOORS-1:0] cur_floor,
    input  logic                complete,
    input  logic                door_alert,
    input  logic                weight_alert,
    output logic [N_FLOORS-1:0] request_floor,
    output logic                req_valid,
    output logic                sched_dir,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy
);

    // Counter must be able to hold DWELL_CYCLES-1; sized from DWELL_CYCLES+1
    // so a dwell of 1 still gets a 1-bit counter.
    localparam int            CW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [N_FLOORS-1:0] pending_next;
    logic [N_FLOORS-1:0] target_next;
    logic                req_valid_next;
    logic                dir_next;
    logic [CW-1:0]       dwell_cnt;
    logic [CW-1:0]       dwell_next;

    logic [N_FLOORS-1:0] pick_target;
    logic                pick_found;
    logic                pick_dir;

    // The picker always looks at the registered pending set, so a call
    // arriving in the SELECT cycle itself waits for the next pick.
    elc_scan_pick #(
        .N_FLOORS (N_FLOORS)
    ) u_scan_pick (
        .pending   (pending),
        .cur_floor (cur_floor),
        .sched_dir (sched_dir),
        .target    (pick_target),
        .found     (pick_found),
        .next_dir  (pick_dir)
    );

    assign busy = (state != IDLE);

    // Next-state and next-output logic. Every registered output is computed
    // here so the values leave the flops clean and glitch-free. Call capture
    // runs first in every state; the DISPATCH completion then masks the
    // target bit out of the merged value, so a same-cycle call for the
    // floor just served is dropped while calls for other floors survive.
    always_comb begin
        state_next     = state;
        pending_next   = pending;
        target_next    = request_floor;
        req_valid_next = req_valid;
        dir_next       = sched_dir;
        dwell_next     = dwell_cnt;

        if (call_valid) begin
            pending_next = pending | call_floor;
        end

        case (state)
            IDLE: begin
                req_valid_next = 1'b0;
                if (pending != '0) begin
                    state_next = SELECT;
                end
            end

            SELECT: begin
                if (pick_found) begin
                    target_next    = pick_target;
                    dir_next       = pick_dir;
                    req_valid_next = 1'b1;
                    state_next     = DISPATCH;
                end else begin
                    state_next = IDLE;
                end
            end

            DISPATCH: begin
                if (complete) begin
                    pending_next   = pending_next & ~request_floor;
                    dwell_next     = DWELL_LOAD;
                    req_valid_next = 1'b0;
                    state_next     = DWELL;
                end
            end

            DWELL: begin
                req_valid_next = 1'b0;
                if (!door_alert && !weight_alert) begin
                    if (dwell_cnt == '0) begin
                        state_next = (pending != '0) ? SELECT : IDLE;
                    end else begin
                        dwell_next = dwell_cnt - CW'(1);
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                req_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset is synchronous and active-low; it
    // wins over everything else, so a complete or call seen during reset is
    // simply discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            pending       <= '0;
            request_floor <= '0;
            req_valid     <= 1'b0;
            sched_dir     <= DIR_UP;
            dwell_cnt     <= '0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            request_floor <= target_next;
            req_valid     <= req_valid_next;
            sched_dir     <= dir_next;
            dwell_cnt     <= dwell_next;
        end
    end

endmodule : elc_request_scheduler

// File: tb/tb_elc_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_elc_request_scheduler
// Directed self-checking bench for elc_request_scheduler (8 floors, dwell 4).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, so each applyStimulus call covers exactly one clock edge.
// ----------------------------------------------------------------------------
module tb_elc_request_scheduler;

    logic       clk;
    logic       reset;
    logic       call_valid;
    logic [7:0] call_floor;
    logic [7:0] cur_floor;
    logic       complete;
    logic       door_alert;
    logic       weight_alert;
    logic [7:0] request_floor;
    logic       req_valid;
    logic       sched_dir;
    logic [7:0] pending;
    logic       busy;

    int checks_total;
    int checks_passed;

    elc_request_scheduler #(
        .N_FLOORS     (8),
        .DWELL_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .cur_floor     (cur_floor),
        .complete      (complete),
        .door_alert    (door_alert),
        .weight_alert  (weight_alert),
        .request_floor (request_floor),
        .req_valid     (req_valid),
        .sched_dir     (sched_dir),
        .pending       (pending),
        .busy          (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, let one rising edge sample them, then drop
    // the single-cycle pulses. Alerts are driven explicitly every call.
    task automatic applyStimulus(input logic cv, input logic [7:0] cf,
                                 input logic cp, input logic da, input logic wa);
        call_valid   = cv;
        call_floor   = cf;
        complete     = cp;
        door_alert   = da;
        weight_alert = wa;
        @(posedge clk);
        #1;
        call_valid = 1'b0;
        call_floor = 8'h00;
        complete   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset        = 1'b0;
        call_valid   = 1'b0;
        call_floor   = 8'h00;
        cur_floor    = 8'h01;
        complete     = 1'b0;
        door_alert   = 1'b0;
        weight_alert = 1'b0;

        // ---- Reset values ----
        idleCycles(2);
        checkOutput("rst_req_valid", {31'd0, req_valid}, 32'd0);
        checkOutput("rst_request_floor", {24'd0, request_floor}, 32'h00);
        checkOutput("rst_sched_dir", {31'd0, sched_dir}, 32'd1);
        checkOutput("rst_pending", {24'd0, pending}, 32'h00);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        // ---- Single call to top floor from floor 0 ----
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_pending_after_E0", {24'd0, pending}, 32'h80);
        checkOutput("t1_busy_after_E0", {31'd0, busy}, 32'd0);
        idleCycles(1);
        checkOutput("t1_busy_after_E1", {31'd0, busy}, 32'd1);
        checkOutput("t1_req_valid_after_E1", {31'd0, req_valid}, 32'd0);
        idleCycles(1);
        checkOutput("t1_req_valid_after_E2", {31'd0, req_valid}, 32'd1);
        checkOutput("t1_request_floor", {24'd0, request_floor}, 32'h80);
        checkOutput("t1_sched_dir", {31'd0, sched_dir}, 32'd1);
        cur_floor = 8'h80;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_req_valid_after_complete", {31'd0, req_valid}, 32'd0);
        checkOutput("t1_pending_after_complete", {24'd0, pending}, 32'h00);
        idleCycles(3);
        checkOutput("t1_busy_in_dwell", {31'd0, busy}, 32'd1);
        idleCycles(1);
        checkOutput("t1_busy_after_dwell", {31'd0, busy}, 32'd0);

        // ---- SCAN order: calls 04,40,02 from floor 3 moving up ----
        cur_floor = 8'h08;
        applyStimulus(1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_pending", {24'd0, pending}, 32'h46);
        idleCycles(2);
        checkOutput("t2_first_target", {24'd0, request_floor}, 32'h40);
        checkOutput("t2_first_dir", {31'd0, sched_dir}, 32'd1);
        idleCycles(2);
        checkOutput("t2_target_held", {24'd0, request_floor}, 32'h40);
        checkOutput("t2_valid_held", {31'd0, req_valid}, 32'd1);
        cur_floor = 8'h40;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_pending_after_first", {24'd0, pending}, 32'h06);
        checkOutput("t2_target_kept_in_dwell", {24'd0, request_floor}, 32'h40);
        idleCycles(4);
        checkOutput("t2_no_early_dispatch", {31'd0, req_valid}, 32'd0);
        idleCycles(1);
        checkOutput("t2_second_valid", {31'd0, req_valid}, 32'd1);
        checkOutput("t2_second_target", {24'd0, request_floor}, 32'h04);
        checkOutput("t2_second_dir", {31'd0, sched_dir}, 32'd0);
        cur_floor = 8'h04;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_pending_after_second", {24'd0, pending}, 32'h02);
        idleCycles(5);
        checkOutput("t2_third_target", {24'd0, request_floor}, 32'h02);
        checkOutput("t2_third_dir", {31'd0, sched_dir}, 32'd0);

        // ---- Door alert stretches dwell by 3 cycles ----
        cur_floor = 8'h02;
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_pending", {24'd0, pending}, 32'h10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        idleCycles(4);
        checkOutput("t3_not_yet_valid_at_7", {31'd0, req_valid}, 32'd0);
        idleCycles(1);
        checkOutput("t3_valid_at_8", {31'd0, req_valid}, 32'd1);
        checkOutput("t3_target", {24'd0, request_floor}, 32'h10);
        checkOutput("t3_dir_reversed_up", {31'd0, sched_dir}, 32'd1);

        // ---- Same-cycle complete and call for the target ----
        cur_floor = 8'h10;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_call_target_no_effect", {24'd0, pending}, 32'h10);
        checkOutput("t4_request_not_withdrawn", {31'd0, req_valid}, 32'd1);
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_clear_wins", {24'd0, pending}, 32'h20);
        idleCycles(5);
        checkOutput("t4_next_target", {24'd0, request_floor}, 32'h20);
        checkOutput("t4_next_valid", {31'd0, req_valid}, 32'd1);

        // ---- Reset during DISPATCH with pending 81 and direction down ----
        cur_floor = 8'h20;
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        idleCycles(5);
        checkOutput("t5_target_down", {24'd0, request_floor}, 32'h01);
        checkOutput("t5_dir_down", {31'd0, sched_dir}, 32'd0);
        applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_pending_81", {24'd0, pending}, 32'h81);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_rst_req_valid", {31'd0, req_valid}, 32'd0);
        checkOutput("t5_rst_pending", {24'd0, pending}, 32'h00);
        checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_rst_dir", {31'd0, sched_dir}, 32'd1);
        checkOutput("t5_rst_request_floor", {24'd0, request_floor}, 32'h00);
        reset = 1'b1;

        // ---- Call for the current floor, weight alert stalls one cycle ----
        cur_floor = 8'h01;
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("t6_target_current", {24'd0, request_floor}, 32'h01);
        checkOutput("t6_valid", {31'd0, req_valid}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_pending_clear", {24'd0, pending}, 32'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idleCycles(3);
        checkOutput("t6_busy_stalled", {31'd0, busy}, 32'd1);
        idleCycles(1);
        checkOutput("t6_busy_falls", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_complete_in_idle_ignored", {31'd0, busy}, 32'd0);
        checkOutput("t6_valid_stays_low", {31'd0, req_valid}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_elc_request_scheduler
